mem_stage: RTL and testbench

Memory-access pipeline stage that consumes the execute stage's `ex_ctrl_bus` over the valid/ready handshake, performs the load or store on the data-memory request/response port, and hands a write-back bundle to the WB stage. It is a single-entry stage holding at most one instruction, and it sits between EXE and WB in the 5-stage core.

---
 rtl/mem_stage.sv | 254 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage
// ---------------------------------------------------------------------------
// Memory-access stage of the 5-stage core, sitting between EXE and WB.
// It holds at most one instruction. A bundle from EXE is taken over the
// left valid/ready handshake. Loads and stores are then issued on the
// data-memory request/response port. The finished write-back bundle is
// presented to WB over the right valid/ready handshake.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   ex_ctrl_bus     213-bit bundle from EXE
//   left_valid      EXE bundle valid
//   left_ready      stage can take a bundle this cycle (combinational)
//   right_valid     mem_ctrl_bus valid toward WB
//   right_ready     WB accepts
//   mem_ctrl_bus    103-bit {inst_valid, PC, Inst, wreg_index, wreg_en, wb_data}
//   mem_bypass      38-bit {wb_data, wreg_index, wreg_en & right_valid}
//   data_req        memory request (high only while requesting)
//   data_we         store request
//   data_addr       word-aligned request address
//   data_wstrb      byte strobes (zero for loads)
//   data_wdata      lane-replicated store data
//   data_gnt        memory accepted the request
//   data_rvalid     read data valid
//   data_rdata      read data word
// ---------------------------------------------------------------------------
module mem_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic [212:0] ex_ctrl_bus,
    input  logic         left_valid,
    output logic         left_ready,
    output logic         right_valid,
    input  logic         right_ready,
    output logic [102:0] mem_ctrl_bus,
    output logic [37:0]  mem_bypass,
    output logic         data_req,
    output logic         data_we,
    output logic [31:0]  data_addr,
    output logic [3:0]   data_wstrb,
    output logic [31:0]  data_wdata,
    input  logic         data_gnt,
    input  logic         data_rvalid,
    input  logic [31:0]  data_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FULL = 2'd3
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    state_t state, next_state;

    // Fields of the incoming EXE bundle
    logic        in_inst_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [4:0]  in_wreg_index;
    logic        in_wreg_en;
    logic [31:0] in_store_data;
    logic [31:0] in_addr;
    logic [2:0]  in_funct3;
    logic        in_is_load;
    logic        in_is_store;
    logic        in_is_mem;
    logic        accept;

    // Bits of the EXE bundle this stage has no use for
    logic        unused_ex_bits;

    // Held instruction
    logic        inst_valid_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [4:0]  wreg_index_q;
    logic        wreg_en_q;
    logic [1:0]  addr_lo_q;
    logic [2:0]  funct3_q;
    logic        is_load_q;
    logic [31:0] wb_data_q;

    // Store encoding of the incoming bundle and load extraction of the held one
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign in_inst_valid  = ex_ctrl_bus[198];
    assign in_pc          = ex_ctrl_bus[165:134];
    assign in_inst        = ex_ctrl_bus[133:102];
    assign in_wreg_index  = ex_ctrl_bus[101:97];
    assign in_wreg_en     = ex_ctrl_bus[96];
    assign in_store_data  = ex_ctrl_bus[95:64];
    assign in_addr        = ex_ctrl_bus[31:0];
    assign in_funct3      = in_inst[14:12];
    assign unused_ex_bits = ^{ex_ctrl_bus[212:199], ex_ctrl_bus[197:166], ex_ctrl_bus[63:32]};

    // A bubble (inst_valid = 0) never touches memory, whatever its opcode.
    assign in_is_load  = in_inst_valid && (in_inst[6:0] == OPC_LOAD);
    assign in_is_store = in_inst_valid && (in_inst[6:0] == OPC_STORE);
    assign in_is_mem   = in_is_load || in_is_store;
    assign accept      = left_valid && left_ready;

    // Strobes and replicated write data for a store. funct3[1:0] gives the size.
    // A halfword ignores addr[0] and a word ignores addr[1:0]. Misaligned
    // accesses are not trapped.
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        if (in_is_store) begin
            case (in_funct3[1:0])
                2'b00: begin
                    st_wstrb = 4'b0001 << in_addr[1:0];
                    st_wdata = {4{in_store_data[7:0]}};
                end
                2'b01: begin
                    st_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{in_store_data[15:0]}};
                end
                default: begin
                    st_wstrb = 4'b1111;
                    st_wdata = in_store_data;
                end
            endcase
        end
    end

    // Pick the addressed byte or half out of the returned word. funct3[2]
    // selects zero- rather than sign-extension.
    always_comb begin
        ld_byte  = 8'h00;
        ld_half  = 16'h0000;
        ld_value = 32'h0;
        case (addr_lo_q)
            2'd0:    ld_byte = data_rdata[7:0];
            2'd1:    ld_byte = data_rdata[15:8];
            2'd2:    ld_byte = data_rdata[23:16];
            default: ld_byte = data_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_value = funct3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_value = funct3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_value = data_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake outputs. A FULL stage draining into WB can
    // take a new bundle in the same cycle, so it follows the IDLE rule then.
    always_comb begin
        next_state  = state;
        left_ready  = 1'b0;
        right_valid = 1'b0;
        case (state)
            IDLE: begin
                left_ready = 1'b1;
                if (accept) begin
                    next_state = in_is_mem ? REQ : FULL;
                end
            end
            REQ: begin
                if (data_gnt) begin
                    next_state = is_load_q ? WAIT : FULL;
                end
            end
            WAIT: begin
                if (data_rvalid) begin
                    next_state = FULL;
                end
            end
            FULL: begin
                right_valid = 1'b1;
                left_ready  = right_ready;
                if (right_ready) begin
                    if (accept) begin
                        next_state = in_is_mem ? REQ : FULL;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath. The bundle is latched on accept. Request fields are registered
    // there and held untouched until the grant. wb_data is written when the
    // result becomes known.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_valid_q <= 1'b0;
            pc_q         <= 32'h0;
            inst_q       <= 32'h0;
            wreg_index_q <= 5'h0;
            wreg_en_q    <= 1'b0;
            addr_lo_q    <= 2'b00;
            funct3_q     <= 3'b000;
            is_load_q    <= 1'b0;
            wb_data_q    <= 32'h0;
            data_req     <= 1'b0;
            data_we      <= 1'b0;
            data_addr    <= 32'h0;
            data_wstrb   <= 4'h0;
            data_wdata   <= 32'h0;
        end else begin
            if (accept) begin
                inst_valid_q <= in_inst_valid;
                pc_q         <= in_pc;
                inst_q       <= in_inst;
                wreg_index_q <= in_wreg_index;
                wreg_en_q    <= in_wreg_en;
                addr_lo_q    <= in_addr[1:0];
                funct3_q     <= in_funct3;
                is_load_q    <= in_is_load;
                if (in_is_mem) begin
                    data_req   <= 1'b1;
                    data_we    <= in_is_store;
                    data_addr  <= {in_addr[31:2], 2'b00};
                    data_wstrb <= st_wstrb;
                    data_wdata <= st_wdata;
                end else begin
                    wb_data_q  <= in_addr;
                end
            end else if ((state == REQ) && data_gnt) begin
                data_req <= 1'b0;
                data_we  <= 1'b0;
                if (!is_load_q) begin
                    wb_data_q <= 32'h0;
                end
            end else if ((state == WAIT) && data_rvalid) begin
                wb_data_q <= ld_value;
            end
        end
    end

    assign mem_ctrl_bus = {inst_valid_q, pc_q, inst_q, wreg_index_q, wreg_en_q, wb_data_q};
    assign mem_bypass   = {wb_data_q, wreg_index_q, wreg_en_q & right_valid};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
// Scoreboard bench for mem_stage. A driver issues bundles and pushes the
// expected write-back bundle and memory request at the moment of accept.
// A memory responder checks requests and answers them with per-transaction
// grant/data delays. A monitor pops and compares every bundle WB takes.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic [212:0] ex_ctrl_bus;
    logic         left_valid;
    logic         left_ready;
    logic         right_valid;
    logic         right_ready;
    logic [102:0] mem_ctrl_bus;
    logic [37:0]  mem_bypass;
    logic         data_req;
    logic         data_we;
    logic [31:0]  data_addr;
    logic [3:0]   data_wstrb;
    logic [31:0]  data_wdata;
    logic         data_gnt;
    logic         data_rvalid;
    logic [31:0]  data_rdata;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .reset       (reset),
        .ex_ctrl_bus (ex_ctrl_bus),
        .left_valid  (left_valid),
        .left_ready  (left_ready),
        .right_valid (right_valid),
        .right_ready (right_ready),
        .mem_ctrl_bus(mem_ctrl_bus),
        .mem_bypass  (mem_bypass),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wstrb  (data_wstrb),
        .data_wdata  (data_wdata),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        is_load;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] rdata;
    } req_t;

    logic [102:0] exp_q[$];
    req_t         req_q[$];

    int checks = 0;
    int fails  = 0;

    // right_ready mode: 0 random, 1 held high, 2 held low
    int rr_mode = 1;
    logic force_rv = 1'b0;
    logic load_pending = 1'b0;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int size = acc_size(f3);
        int off  = int'(addr[1:0]);
        int base = off - (off % size);
        logic [63:0] v, mask;
        v    = {32'h0, rdata} >> (8 * base);
        mask = (64'd1 << (8 * size)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && size < 4 && (((v >> (8 * size - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                               output logic [3:0] strb, output logic [31:0] wd);
        int size = acc_size(f3);
        int off  = int'(addr[1:0]);
        int base = off - (off % size);
        strb = 4'b0000;
        wd   = 32'h0;
        for (int i = 0; i < 4; i++) begin
            wd[8*i +: 8] = sd[8*(i % size) +: 8];
            if (i >= base && i < base + size) strb[i] = 1'b1;
        end
    endtask

    function automatic logic [212:0] make_bus(input logic iv, input logic [6:0] op, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] sd,
                                              input logic [4:0] idx, input logic en);
        logic [212:0] b;
        logic [31:0]  inst;
        for (int i = 0; i < 213; i++) b[i] = 1'($urandom);
        inst        = $urandom;
        inst[6:0]   = op;
        inst[14:12] = f3;
        b[198]      = iv;
        b[165:134]  = $urandom;
        b[133:102]  = inst;
        b[101:97]   = idx;
        b[96]       = en;
        b[95:64]    = sd;
        b[31:0]     = addr;
        return b;
    endfunction

    // ---------------- driver ----------------
    task automatic applyStimulus(input logic [212:0] b, input int gnt_dly, input int rv_dly,
                                 input logic [31:0] rdata, output int waited);
        logic        iv    = b[198];
        logic [6:0]  op    = b[108:102];
        logic [2:0]  f3    = b[116:114];
        logic [31:0] addr  = b[31:0];
        logic        ld    = iv && (op == 7'h03);
        logic        st    = iv && (op == 7'h23);
        logic [31:0] wb;
        bit          done  = 0;
        req_t        r;
        ex_ctrl_bus = b;
        left_valid  = 1'b1;
        waited      = 0;
        while (!done) begin
            @(negedge clk);
            if (left_ready) begin
                wb = ld ? model_load(f3, addr, rdata) : (st ? 32'h0 : addr);
                exp_q.push_back({iv, b[165:134], b[133:102], b[101:97], b[96], wb});
                if (ld || st) begin
                    r.addr    = {addr[31:2], 2'b00};
                    r.we      = st;
                    r.is_load = ld;
                    r.gnt_dly = gnt_dly;
                    r.rv_dly  = rv_dly;
                    r.rdata   = rdata;
                    if (st) model_store(f3, addr, b[95:64], r.wstrb, r.wdata);
                    else begin r.wstrb = 4'b0000; r.wdata = 32'h0; end
                    req_q.push_back(r);
                end
                done = 1;
            end else begin
                waited++;
                if (waited > 300) begin
                    checkOutput("accept_timeout", left_ready, 1);
                    done = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        left_valid = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!right_valid && n < 80);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || right_valid) && k < 500) begin
            @(negedge clk);
            k++;
        end
        checkOutput("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- right_ready generator ----------------
    initial begin
        right_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       right_ready = ($urandom % 3) != 0;
                2:       right_ready = 1'b0;
                default: right_ready = 1'b1;
            endcase
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        bit   in_req = 0, gnt_real = 0, rv_real = 0;
        int   gcnt = 0, rvcnt = 0;
        logic [31:0] cur_rdata = 0;
        req_t cur;
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
        data_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                req_q.delete();
                in_req = 0; gnt_real = 0; rv_real = 0;
                load_pending = 1'b0;
                data_gnt = 1'b0;
                data_rvalid = 1'b0;
                continue;
            end
            if (rv_real) load_pending = 1'b0;
            if (gnt_real) begin
                cur    = req_q.pop_front();
                in_req = 0;
                if (cur.is_load) begin
                    load_pending = 1'b1;
                    rvcnt        = cur.rv_dly;
                    cur_rdata    = cur.rdata;
                end
            end
            gnt_real = 0; rv_real = 0;
            data_gnt = 1'b0;
            data_rvalid = 1'b0;
            if (data_req) begin
                if (req_q.size() == 0) begin
                    checkOutput("unexpected_req", data_req, 0);
                end else begin
                    if (!in_req) begin
                        in_req = 1;
                        gcnt   = req_q[0].gnt_dly;
                    end
                    checkOutput("req_addr", data_addr, req_q[0].addr);
                    checkOutput("req_we", data_we, req_q[0].we);
                    checkOutput("req_wstrb", data_wstrb, req_q[0].wstrb);
                    if (!req_q[0].is_load) checkOutput("req_wdata", data_wdata, req_q[0].wdata);
                    if (gcnt == 0) begin
                        data_gnt = 1'b1;
                        gnt_real = 1;
                    end else begin
                        gcnt--;
                    end
                end
            end else begin
                data_gnt = ($urandom % 8) == 0;
            end
            if (load_pending) begin
                if (rvcnt == 0) begin
                    data_rvalid = 1'b1;
                    data_rdata  = cur_rdata;
                    rv_real     = 1;
                end else begin
                    rvcnt--;
                    data_rdata = $urandom;
                end
            end else begin
                data_rvalid = force_rv || (($urandom % 6) == 0);
                data_rdata  = $urandom;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                continue;
            end
            if (right_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_valid", right_valid, 0);
                end else begin
                    checkOutput("mem_ctrl_bus", mem_ctrl_bus, exp_q[0]);
                    checkOutput("mem_bypass", mem_bypass, {exp_q[0][31:0], exp_q[0][37:33], exp_q[0][32]});
                    if (right_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, fails);
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- main sequence ----------------
    int          w, n, kind, k;
    logic [212:0] b;
    logic [6:0]  op;
    logic [2:0]  f3;

    initial begin
        reset       = 1'b1;
        left_valid  = 1'b0;
        ex_ctrl_bus = '0;
        repeat (2) @(posedge clk);
        #1;
        // left_valid raised during reset must be ignored
        left_valid  = 1'b1;
        ex_ctrl_bus = make_bus(1'b1, 7'h33, 3'b000, 32'hDEAD0000, 32'h0, 5'd1, 1'b1);
        @(negedge clk);
        checkOutput("rst_right_valid", right_valid, 0);
        checkOutput("rst_data_req", data_req, 0);
        checkOutput("rst_data_we", data_we, 0);
        checkOutput("rst_data_addr", data_addr, 0);
        checkOutput("rst_data_wstrb", data_wstrb, 0);
        checkOutput("rst_data_wdata", data_wdata, 0);
        checkOutput("rst_mem_ctrl_bus", mem_ctrl_bus, 0);
        checkOutput("rst_mem_bypass", mem_bypass, 0);
        checkOutput("rst_left_ready", left_ready, 1);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        left_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_ignored_left_valid", right_valid, 0);
        @(posedge clk);
        #1;

        // Non-memory, latency 1, then back-to-back flow with no bubble
        $display("[TB] non-memory and throughput");
        applyStimulus(make_bus(1'b1, 7'h33, 3'b000, 32'h12345678, $urandom, 5'd3, 1'b1), 0, 0, 0, w);
        waitValid(n);
        checkOutput("alu_latency", n, 1);
        checkOutput("alu_wb_data", mem_ctrl_bus[31:0], 32'h12345678);
        @(posedge clk);
        #1;
        applyStimulus(make_bus(1'b1, 7'h13, 3'b000, $urandom, $urandom, 5'd4, 1'b1), 0, 0, 0, w);
        applyStimulus(make_bus(1'b1, 7'h37, 3'b000, $urandom, $urandom, 5'd5, 1'b1), 0, 0, 0, w);
        checkOutput("b2b_no_bubble", w, 0);
        applyStimulus(make_bus(1'b1, 7'h33, 3'b000, $urandom, $urandom, 5'd6, 1'b0), 0, 0, 0, w);
        checkOutput("b2b_no_bubble2", w, 0);
        drain();

        // lb with sign extension
        $display("[TB] lb sign-extend");
        applyStimulus(make_bus(1'b1, 7'h03, 3'b000, 32'h00001003, $urandom, 5'd7, 1'b1), 0, 0, 32'h80FFFF00, w);
        waitValid(n);
        checkOutput("lb_latency", n, 3);
        checkOutput("lb_wb_data", mem_ctrl_bus[31:0], 32'hFFFFFF80);
        drain();

        // sh with a three-cycle grant delay
        $display("[TB] sh with delayed grant");
        applyStimulus(make_bus(1'b1, 7'h23, 3'b001, 32'h00002002, 32'hAAAABEEF, 5'd0, 1'b0), 3, 0, 0, w);
        @(negedge clk);
        checkOutput("sh_wstrb", data_wstrb, 4'b1100);
        checkOutput("sh_wdata", data_wdata, 32'hBEEFBEEF);
        checkOutput("sh_we", data_we, 1);
        n = 1;
        while (!right_valid && n < 80) begin
            @(negedge clk);
            n++;
        end
        checkOutput("sh_latency", n, 5);
        drain();

        // Backpressure, then same-cycle accept as WB frees up
        $display("[TB] backpressure");
        rr_mode = 2;
        @(posedge clk);
        #1;
        applyStimulus(make_bus(1'b1, 7'h33, 3'b000, $urandom, $urandom, 5'd9, 1'b1), 0, 0, 0, w);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bp_right_valid", right_valid, 1);
            checkOutput("bp_left_ready", left_ready, 0);
            checkOutput("bp_bypass_en", mem_bypass[0], 1);
        end
        rr_mode = 1;
        @(posedge clk);
        #1;
        applyStimulus(make_bus(1'b1, 7'h13, 3'b000, $urandom, $urandom, 5'd10, 1'b1), 0, 0, 0, w);
        checkOutput("bp_same_cycle_accept", w, 0);
        drain();

        // Bubble with a load opcode
        $display("[TB] bubble");
        applyStimulus(make_bus(1'b0, 7'h03, 3'b010, $urandom, $urandom, 5'd11, 1'b1), 0, 0, 0, w);
        waitValid(n);
        checkOutput("bubble_latency", n, 1);
        drain();

        // Reset while waiting for load data
        $display("[TB] reset in WAIT");
        applyStimulus(make_bus(1'b1, 7'h03, 3'b010, 32'h00003000, $urandom, 5'd12, 1'b1), 0, 60, 32'h11223344, w);
        k = 0;
        while (!load_pending && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reached_wait", load_pending, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        force_rv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rw_right_valid", right_valid, 0);
            checkOutput("rw_data_req", data_req, 0);
            checkOutput("rw_mem_ctrl_bus", mem_ctrl_bus, 0);
            checkOutput("rw_mem_bypass", mem_bypass, 0);
        end
        force_rv = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and memory delays
        $display("[TB] random traffic");
        rr_mode = 0;
        for (int t = 0; t < 150; t++) begin
            repeat ($urandom % 3) begin
                @(posedge clk);
                #1;
            end
            kind = $urandom % 4;
            case (kind)
                0: begin
                    case ($urandom % 4)
                        0: op = 7'h33;
                        1: op = 7'h13;
                        2: op = 7'h37;
                        default: op = 7'h63;
                    endcase
                    b = make_bus(1'b1, op, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
                end
                1: begin
                    case ($urandom % 5)
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                    b = make_bus(1'b1, 7'h03, f3, $urandom, $urandom, 5'($urandom), 1'($urandom));
                end
                2: begin
                    f3 = 3'($urandom % 3);
                    b = make_bus(1'b1, 7'h23, f3, $urandom, $urandom, 5'($urandom), 1'($urandom));
                end
                default: begin
                    op = ($urandom % 2) ? 7'h03 : 7'h23;
                    b = make_bus(1'b0, op, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
                end
            endcase
            applyStimulus(b, $urandom % 4, $urandom % 4, $urandom, w);
        end
        rr_mode = 1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
